muldiv_unit: RTL

Iterative multiply/divide execution unit. It consumes the 5-bit ALU control code produced by the ALU control decoder and executes the long-latency operations: OPMUL, OPMULH, OPMULHU, OPMULHSU, OPDIV, OPDIVU, OPREM and OPREMU. It sits beside the single-cycle ALU in the execute stage. A start/busy/done handshake lets the control unit stall the datapath while an operation is in flight.

---
 rtl/muldiv_unit_pkg.sv | 32 +++
 rtl/muldiv_unit_step.sv | 40 ++++
 rtl/muldiv_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared ALU control encoding (OP* codes) and op-class helpers for the
// multiply/divide unit.
package muldiv_unit_pkg;

    // ALU control codes shared with the ALU control decoder
    localparam logic [4:0] OPAND    = 5'd0;
    localparam logic [4:0] OPOR     = 5'd1;
    localparam logic [4:0] OPADD    = 5'd2;
    localparam logic [4:0] OPSUB    = 5'd6;
    localparam logic [4:0] OPSLT    = 5'd7;
    localparam logic [4:0] OPNOR    = 5'd12;
    localparam logic [4:0] OPMUL    = 5'd16;
    localparam logic [4:0] OPMULH   = 5'd17;
    localparam logic [4:0] OPMULHSU = 5'd18;
    localparam logic [4:0] OPMULHU  = 5'd19;
    localparam logic [4:0] OPDIV    = 5'd20;
    localparam logic [4:0] OPDIVU   = 5'd21;
    localparam logic [4:0] OPREM    = 5'd22;
    localparam logic [4:0] OPREMU   = 5'd23;

    // True for any op this unit executes
    function automatic logic is_muldiv(input logic [4:0] op);
        return op inside {OPMUL, OPMULH, OPMULHSU, OPMULHU,
                          OPDIV, OPDIVU, OPREM, OPREMU};
    endfunction

    // True for the multiply family
    function automatic logic is_mul(input logic [4:0] op);
        return op inside {OPMUL, OPMULH, OPMULHSU, OPMULHU};
    endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One combinational iteration of either radix-2 shift-add multiply or
// restoring division. acc is the high half (partial product / partial
// remainder), opnd is the low half (multiplier shifting out / dividend
// shifting out while quotient bits shift in), b is multiplicand or divisor.
module muldiv_step #(
    parameter int WIDTH = 64
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] opnd_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;

    // Single multiply or divide step selected by div_i
    always_comb begin
        sum    = {1'b0, acc_i} + (opnd_i[0] ? {1'b0, b_i} : '0);
        rem_sh = {acc_i, opnd_i[WIDTH-1]};
        // When rem_sh >= b the true difference is < b, so WIDTH bits suffice
        diff   = rem_sh[WIDTH-1:0] - b_i;
        if (div_i) begin
            if (rem_sh >= {1'b0, b_i}) begin
                acc_o  = diff;
                opnd_o = {opnd_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o  = rem_sh[WIDTH-1:0];
                opnd_o = {opnd_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o  = sum[WIDTH:1];
            opnd_o = {sum[0], opnd_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: MUL/MULH/MULHU/MULHSU/DIV/DIVU/REM/REMU.
// Operates on magnitudes, fixes the sign in a final FIX cycle.
// Optional: MULDIV_EARLY_OUT_EN -- divide-by-zero, signed overflow and
// multiply-by-zero finish in one cycle instead of WIDTH+2.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iStart,
    input  logic [4:0]       iALUControl,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oResult
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [4:0]       op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, res_q, res_d;
    logic             neg_q, neg_d, dz_q, dz_d;

    logic             acc_ok, in_mul, a_neg, b_neg, in_dz;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_hi, step_lo, fix_res;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] q_s, r_s;

    // Request decode: acceptance, operand magnitudes and special cases
    always_comb begin
        acc_ok = iStart && is_muldiv(iALUControl) &&
                 (state_q == S_IDLE || state_q == S_DONE);
        in_mul = is_mul(iALUControl);
        a_neg  = iA[WIDTH-1] && (iALUControl inside {OPMULH, OPMULHSU, OPDIV, OPREM});
        b_neg  = iB[WIDTH-1] && (iALUControl inside {OPMULH, OPDIV, OPREM});
        a_mag  = a_neg ? -iA : iA;
        b_mag  = b_neg ? -iB : iB;
        in_dz  = !in_mul && (iB == '0);
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic             in_ovf, in_zero, early;
    logic [WIDTH-1:0] early_res;

    // Results for the cases that skip the iterative datapath
    always_comb begin
        in_ovf  = (iALUControl inside {OPDIV, OPREM}) &&
                  (iA == {1'b1, {(WIDTH-1){1'b0}}}) && (iB == '1);
        in_zero = in_mul && ((iA == '0) || (iB == '0));
        early   = in_dz || in_ovf || in_zero;
        early_res = '0;
        if (in_dz)
            early_res = (iALUControl inside {OPDIV, OPDIVU}) ? '1 : iA;
        else if (in_ovf)
            early_res = (iALUControl == OPDIV) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
    end
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_i  (!is_mul(op_q)),
        .acc_i  (hi_q),
        .opnd_i (lo_q),
        .b_i    (b_q),
        .acc_o  (step_hi),
        .opnd_o (step_lo)
    );

    // Sign fix and half/quotient/remainder select. Overflow and
    // divide-by-zero remainder fall out of the magnitude datapath naturally;
    // only the divide-by-zero quotient needs an override.
    always_comb begin
        prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        q_s    = neg_q ? -lo_q : lo_q;
        r_s    = neg_q ? -hi_q : hi_q;
        case (op_q)
            OPMUL:                      fix_res = prod_s[WIDTH-1:0];
            OPMULH, OPMULHU, OPMULHSU:  fix_res = prod_s[2*WIDTH-1:WIDTH];
            OPDIV, OPDIVU:              fix_res = dz_q ? '1 : q_s;
            default:                    fix_res = r_s;
        endcase
    end

    // FSM next state and datapath next values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        res_d   = res_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        case (state_q)
            S_RUN: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                res_d   = fix_res;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase
        if (acc_ok) begin
            op_d    = iALUControl;
            neg_d   = (iALUControl == OPREM) ? a_neg : (a_neg ^ b_neg);
            dz_d    = in_dz;
            hi_d    = '0;
            lo_d    = in_mul ? b_mag : a_mag;
            b_d     = in_mul ? a_mag : b_mag;
            cnt_d   = CW'(WIDTH - 1);
            state_d = S_RUN;
`ifdef MULDIV_EARLY_OUT_EN
            if (early) begin
                res_d   = early_res;
                state_d = S_DONE;
            end
`endif
        end
    end

    // State and datapath registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            res_q   <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            res_q   <= res_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
        end
    end

    assign oBusy   = (state_q == S_RUN) || (state_q == S_FIX);
    assign oDone   = (state_q == S_DONE);
    assign oResult = res_q;

endmodule
